// File: rtl/matrix_operand_loader.sv
// Byte-serial operand loader for the 2x2 matrix multiplier: gathers an 8-byte frame
// into shadow registers, publishes it to A*/B* and pulses start, with framing checks.
module matrix_operand_loader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] A0,
  output logic [DATA_W-1:0] A1,
  output logic [DATA_W-1:0] A2,
  output logic [DATA_W-1:0] A3,
  output logic [DATA_W-1:0] B0,
  output logic [DATA_W-1:0] B1,
  output logic [DATA_W-1:0] B2,
  output logic [DATA_W-1:0] B3,
  output logic              start,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  // The gap counter is loaded with GAP_CYCLES-1 and counts down to zero.
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  shadow_q [7];
  logic [DATA_W-1:0]  shadow_d [7];
  logic [DATA_W-1:0]  ops_q [8];
  logic [DATA_W-1:0]  ops_d [8];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               err_q, err_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ops_d    = ops_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a transfer.
        if (in_valid) begin
          if (idx_q == 3'd7 && in_last) begin
            for (int unsigned i = 0; i < 7; i++) begin
              ops_d[i] = shadow_q[i];
            end
            ops_d[7] = in_data;
            cnt_d    = cnt_q + 1'b1;
            idx_d    = '0;
            state_d  = S_FIRE;
          end else if (idx_q == 3'd7 || in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            for (int unsigned i = 0; i < 7; i++) begin
              if (idx_q == 3'(i)) shadow_d[i] = in_data;
            end
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_FIRE: begin
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_INIT);
        end else begin
          state_d = S_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_LOAD;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      ops_q    <= '{default: '0};
      cnt_q    <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ops_q    <= ops_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign start     = (state_q == S_FIRE);
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

  assign A0 = ops_q[0];
  assign A1 = ops_q[1];
  assign A2 = ops_q[2];
  assign A3 = ops_q[3];
  assign B0 = ops_q[4];
  assign B1 = ops_q[5];
  assign B2 = ops_q[6];
  assign B3 = ops_q[7];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: two instances (GAP=2/CNT_W=16 and GAP=0/CNT_W=2) share
// one stimulus stream and are compared every cycle against a frame-level reference model.
module tb_matrix_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        rdy0, rdy1, st0, st1, fe0, fe1;
  logic [7:0]  ops0 [8];
  logic [7:0]  ops1 [8];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  matrix_operand_loader #(.DATA_W(8), .GAP_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0),
    .A0(ops0[0]), .A1(ops0[1]), .A2(ops0[2]), .A3(ops0[3]),
    .B0(ops0[4]), .B1(ops0[5]), .B2(ops0[6]), .B3(ops0[7]),
    .start(st0), .frame_err(fe0), .frame_cnt(cnt0)
  );

  matrix_operand_loader #(.DATA_W(8), .GAP_CYCLES(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1),
    .A0(ops1[0]), .A1(ops1[1]), .A2(ops1[2]), .A3(ops1[3]),
    .B0(ops1[4]), .B1(ops1[5]), .B2(ops1[6]), .B3(ops1[7]),
    .start(st1), .frame_err(fe1), .frame_cnt(cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a frame buffer plus a count of cycles during which input is refused.
  const int   GAPV [2] = '{2, 0};
  const int   MASK [2] = '{65535, 3};
  int         fill [2];
  logic [7:0] fbuf [2][8];
  logic [7:0] mops [2][8];
  bit         mstart [2];
  bit         merr [2];
  int         mcnt [2];
  int         busy [2];

  task automatic check(input string name, input int u, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%0h exp=%0h t=%0t", name, u, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_dut(input int u);
    logic [63:0] p = '0;
    for (int i = 0; i < 8; i++) p = (p << 8) | 64'(u == 0 ? ops0[i] : ops1[i]);
    return p;
  endfunction

  function automatic logic [63:0] pack_model(input int u);
    logic [63:0] p = '0;
    for (int i = 0; i < 8; i++) p = (p << 8) | 64'(mops[u][i]);
    return p;
  endfunction

  task automatic mstep(input int u, input logic r, input logic v, input logic [7:0] d,
                       input logic l);
    if (r) begin
      fill[u] = 0; mstart[u] = 0; merr[u] = 0; mcnt[u] = 0; busy[u] = 0;
      for (int i = 0; i < 8; i++) mops[u][i] = 8'h00;
      return;
    end
    mstart[u] = 0;
    merr[u]   = 0;
    if (busy[u] > 0) begin
      busy[u]--;
    end else if (v) begin
      fbuf[u][fill[u]] = d;
      fill[u]++;
      if (l || fill[u] == 8) begin
        if (l && fill[u] == 8) begin
          for (int i = 0; i < 8; i++) mops[u][i] = fbuf[u][i];
          mcnt[u]   = (mcnt[u] + 1) & MASK[u];
          busy[u]   = 1 + GAPV[u];
          mstart[u] = 1;
        end else begin
          merr[u] = 1;
        end
        fill[u] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < 2; u++) begin
      check("m_ready", u, 64'(u == 0 ? rdy0 : rdy1), 64'(busy[u] == 0));
      check("m_start", u, 64'(u == 0 ? st0 : st1), 64'(mstart[u]));
      check("m_err",   u, 64'(u == 0 ? fe0 : fe1), 64'(merr[u]));
      check("m_cnt",   u, (u == 0) ? 64'(cnt0) : 64'(cnt1), 64'(mcnt[u]));
      check("m_ops",   u, pack_dut(u), pack_model(u));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    rst = r; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    for (int u = 0; u < 2; u++) mstep(u, r, v, d, l);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send8(input logic [63:0] f, input logic with_last);
    for (int i = 0; i < 8; i++) step(1'b1, f[63-8*i -: 8], with_last && (i == 7), 1'b0);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        st;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int low;
    int last_s;
    int nstarts;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 8'(i + 1), (i == 7), (i != 7), (i == 7), 1'b0, (i == 7) ? 16'd1 : 16'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_ready", 0, 64'(rdy0), 64'd1);
    check("rst_start", 0, 64'(st0), 64'd0);
    check("rst_cnt",   0, 64'(cnt0), 64'd0);
    check("rst_ops",   0, pack_dut(0), 64'd0);

    // Basic frame 1..8, table driven
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, 1'b0);
      check("tbl_ready", i, 64'(rdy0), 64'(tbl[i].rdy));
      check("tbl_start", i, 64'(st0),  64'(tbl[i].st));
      check("tbl_err",   i, 64'(fe0),  64'(tbl[i].err));
      check("tbl_cnt",   i, 64'(cnt0), 64'(tbl[i].cnt));
    end
    check("t1_ops", 0, pack_dut(0), 64'h0102030405060708);
    check("t1_C0", 0, 64'(int'(ops0[0]) * int'(ops0[4]) + int'(ops0[1]) * int'(ops0[6])), 64'd19);
    check("t1_C1", 0, 64'(int'(ops0[0]) * int'(ops0[5]) + int'(ops0[1]) * int'(ops0[7])), 64'd22);
    check("t1_C2", 0, 64'(int'(ops0[2]) * int'(ops0[4]) + int'(ops0[3]) * int'(ops0[6])), 64'd43);
    check("t1_C3", 0, 64'(int'(ops0[2]) * int'(ops0[5]) + int'(ops0[3]) * int'(ops0[7])), 64'd50);

    // Early in_last on 5th byte, then a clean frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA1 + i), (i == 4), 1'b0);
    check("t2_err",   0, 64'(fe0), 64'd1);
    check("t2_nost",  0, 64'(st0), 64'd0);
    check("t2_hold",  0, pack_dut(0), 64'h0102030405060708);
    send8(64'h0200000203040506, 1'b1);
    check("t2_start", 0, 64'(st0), 64'd1);
    check("t2_ops",   0, pack_dut(0), 64'h0200000203040506);
    idle(3);

    // 8th byte without in_last, next byte restarts at index 0
    send8(64'h3031323334353637, 1'b0);
    check("t3_err",   0, 64'(fe0), 64'd1);
    check("t3_nost",  0, 64'(st0), 64'd0);
    send8(64'h0B0C0D0E0F101112, 1'b1);
    check("t3_start", 0, 64'(st0), 64'd1);
    check("t3_ops",   0, pack_dut(0), 64'h0B0C0D0E0F101112);
    idle(3);

    // in_valid toggling: only handshaked bytes captured, then 1+2 refused cycles
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b1, 8'(8'h40 + i / 2), (i == 14), 1'b0);
      else            step(1'b0, 8'hEE, 1'b1, 1'b0);
    end
    // last transfer was i=14; i=15 was an idle cycle, so start has passed: redo timing check
    check("t4_ops", 0, pack_dut(0), 64'h4041424344454647);
    idle(3);
    send8(64'h5051525354555657, 1'b1);
    check("t4_start", 0, 64'(st0), 64'd1);
    low = (rdy0 == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h99, 1'b0, 1'b0);
      if (rdy0) break;
      low++;
    end
    check("t4_lowcyc", 0, 64'(low), 64'd3);

    // Reset mid-frame discards partial bytes
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send8(64'h090A0B0C0D0E0F10, 1'b1);
    check("t5_ops", 0, pack_dut(0), 64'h090A0B0C0D0E0F10);
    check("t5_cnt", 0, 64'(cnt0), 64'd1);
    idle(3);

    // Zero-gap instance: continuous frames, period 9, 2-bit counter wraps
    step(1'b0, 8'h00, 1'b0, 1'b1);
    last_s  = -1;
    nstarts = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'($urandom), (fill[1] == 7), 1'b0);
      if (st1) begin
        nstarts++;
        if (last_s >= 0) check("t6_period", 1, 64'(k - last_s), 64'd9);
        last_s = k;
      end
    end
    check("t6_nstarts", 1, 64'(nstarts), 64'd4);
    check("t6_wrap",    1, 64'(cnt1), 64'd0);

    // Randomized traffic with occasional framing errors and resets
    for (int k = 0; k < 1500; k++) begin
      logic r, v, l;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = (fill[0] == 7) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      step(v, 8'($urandom), l, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
